// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex segment codes
// and the slot FSM state encoding.
package seven_seg_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 15 first: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return SEG_CODES[value];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Bundle between the value producer and the scan driver, plus the display pins
// the driver presents back.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    data_valid;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   AN;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output data_in, dp_in, data_valid, digit_en,
    input  AN, seg, dp, frame_done
  );

  modport slave (
    input  data_in, dp_in, data_valid, digit_en,
    output AN, seg, dp, frame_done
  );
endinterface

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex digit to active-low {g,f,e,d,c,b,a} segment decoder.
module seven_seg_hex_decoder
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = hex_to_seg(hex);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with per-slot blanking and
// frame-synchronous (tear-free) data updates.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLANK_TICKS = 1_000
) (
  input logic                    clk,
  input logic                    rst,
  seven_seg_scan_driver_if.slave bus
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  state_e        state_q, state_d;

  logic [NUM_DIGITS-1:0][3:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                       pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0][3:0] shown_data_q, shown_data_d;
  logic [NUM_DIGITS-1:0]      shown_dp_q, shown_dp_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [NUM_DIGITS-1:0][3:0] data_in_vec;
  logic [NUM_DIGITS-1:0]      idx_onehot;
  logic [6:0]                 cur_seg;
  logic                       slot_end;
  logic                       wrap;

  assign data_in_vec = bus.data_in;
  assign slot_end    = (tick_q == TICK_LAST);
  assign wrap        = slot_end && (idx_q == IDX_LAST);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
      assign idx_onehot[gi] = (idx_q == IW'(gi));
    end
  endgenerate

  seven_seg_hex_decoder u_decoder (
    .hex   (shown_data_q[idx_q]),
    .seg_n (cur_seg)
  );

  // Prescaler and digit index
  always_comb begin
    tick_d = tick_q + TW'(1);
    idx_d  = idx_q;
    if (slot_end) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (tick_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)             state_d = ST_BLANK;
      default:                            state_d = ST_BLANK;
    endcase
  end

  // A strobe landing on the wrap cycle goes straight to the shown bank so it
  // is not held back a whole extra frame.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    shown_data_d = shown_data_q;
    shown_dp_d   = shown_dp_q;
    if (wrap) begin
      if (bus.data_valid) begin
        shown_data_d = data_in_vec;
        shown_dp_d   = bus.dp_in;
        pend_flag_d  = 1'b0;
      end else if (pend_flag_q) begin
        shown_data_d = pend_data_q;
        shown_dp_d   = pend_dp_q;
        pend_flag_d  = 1'b0;
      end
    end else if (bus.data_valid) begin
      pend_data_d = data_in_vec;
      pend_dp_d   = bus.dp_in;
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == ST_SHOW) begin
      an_d  = bus.digit_en[idx_q] ? ~idx_onehot : '1;
      seg_d = cur_seg;
      dp_d  = ~shown_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      shown_data_q <= '0;
      shown_dp_q   <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      shown_data_q <= shown_data_d;
      shown_dp_q   <= shown_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = wrap;

endmodule
